msrv32_csr_unit_param: RTL and testbench
========================================

Name: msrv32_csr_unit_param

Overview:
Parametrised machine-mode CSR unit for the msrv32 core, next generation of the CSR file. It adds true CSRRW/RS/RC/immediate read-modify-write semantics, field-level write masking and MIE/MPIE stacking on trap entry and mret. It also adds 2-flop interrupt synchronisers, a configurable counter width with high-half access, and N hardware performance counters. It sits beside the writeback stage and feeds the trap/PC-mux logic.

Parameters:
XLEN, 32, datapath width (32 only supported; kept symbolic)
CNT_WIDTH, 64, width of mcycle/minstret/mhpmcounters (33..64 legal; 32 gives zero high halves)
NUM_HPM, 2, number of mhpmcounterN (1..8), mapped from N=3
MTVEC_RESET, 32'h0000_0000, reset value of mtvec

Ports:
ms_riscv32_mp_clk_in  in  1  clock
ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset
wr_en_in  in  1  CSR instruction commits this cycle
csr_addr_in  in  12  CSR address
csr_op_in  in  3  {imm, op[1:0]}; op 01=RW, 10=RS, 11=RC, 00=none
csr_uimm_in  in  5  immediate source
csr_data_in  in  XLEN  rs1 source
pc_in  in  XLEN  PC saved to mepc
iadder_in  in  XLEN  faulting address for mtval
i_or_e_in  in  1  1=interrupt, 0=exception
cause_in  in  4  cause code
set_cause_in, set_epc_in  in  1 each  trap entry strobes
mie_clear_in  in  1  trap entry: stack MIE
mie_set_in  in  1  mret: unstack MIE
instret_inc_in  in  1  instruction retired
ms_riscv32_mp_eirq_in, ms_riscv32_mp_tirq_in, ms_riscv32_mp_sirq_in  in  1 each  async IRQ lines
ms_riscv32_mp_rc_in  in  64  real-time counter
hpm_event_in  in  NUM_HPM  per-counter increment events
csr_data_out  out  XLEN  old CSR value (combinational)
illegal_csr_out  out  1  illegal access (combinational)
mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out  out  1 each  status/enable/pending
trap_address_out  out  XLEN  trap target
epc_out  out  XLEN  mepc

Behaviour:
- Reset: mtvec=MTVEC_RESET, every other CSR, counter and synchroniser 0; all outputs 0 except trap_address_out=MTVEC_RESET base.
- src = imm ? {27'b0,uimm} : csr_data_in. RW: new=src; RS: old|src; RC: old&~src. RS/RC with src==0 perform no write. op==00: no access.
- Write takes effect next edge; csr_data_out always shows pre-write value.
- mstatus (300): only MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; rest 0.
- mie (304): only bits 3,7,11 writable. mip (344): bits 11/7/3 = synchronised e/t/s IRQ (2 cycles latency), writes ignored.
- mtvec (305): base [31:2] writable; mode[1:0] per optional feature. mepc (341): bits[1:0] forced 0. mscratch (340): full.
- mcause (342): {int, 27'b0, code}. mtval (343): full.
- Trap entry: set_epc -> mepc<=pc_in. set_cause -> mcause<={i_or_e,code}; mtval<=exception ? iadder_in : 0. mie_clear -> MPIE<=MIE, MIE<=0. mret (mie_set) -> MIE<=MPIE, MPIE<=1.
- Same-cycle priority: trap-entry/mret updates beat CSR writes to the same register; mie_clear beats mie_set.
- Counters: mcycle (B00/B80) increments every cycle; minstret (B02/B82) on instret_inc_in; mhpmcounterN (B03+i/B83+i) on hpm_event_in[i]. All wrap modulo 2^CNT_WIDTH. A write to either half replaces that half only and suppresses that cycle's increment. High halves are zero-extended bits [CNT_WIDTH-1:32].
- time (C01/C81): read-only view of rc_in.
- illegal_csr_out=1 when op!=00 and either the address is unimplemented or addr[11:10]==2'b11 with a write that would occur. Illegal accesses change no state; unimplemented reads return 0.
- Outputs mie_out=mstatus[3], meie/mtie/msie=mie[11/7/3], meip/mtip/msip=mip[11/7/3], epc_out=mepc.

Optional Feature:
MSRV32_CSR_VECTORED_EN.
- Defined: mtvec[0] writable. If mode==01 and mcause interrupt, trap_address_out = base + 4*code; otherwise base.
- Undefined: mtvec[1:0] read 0, writes ignored, trap_address_out = {base,2'b00}.

Decomposition:
- Package msrv32_csr_pkg: CSR address localparams, op encodings, mstatus/mie/mip bit indices, cause codes.
- Sub-module msrv32_csr_counter(WIDTH): inc, wr_lo, wr_hi, wdata, value; instantiated for mcycle, minstret and each mhpmcounter via generate.

Test Plan:
- Reset with MTVEC_RESET=32'h100 -> trap_address_out=32'h100, csr_data_out for 300 reads 32'h1800.
- CSRRS 304 src=32'hFFFF_FFFF, then read -> 32'h0000_0888; CSRRC src=0 -> no change, illegal_csr_out=0.
- MIE=1, assert set_epc/set_cause/mie_clear with pc=32'h40, exception code 2, iadder=32'hDEAD -> mepc=32'h40, mcause=2, mtval=32'hDEAD, MIE=0, MPIE=1. Then mie_set -> MIE=1, MPIE=1.
- Pulse eirq at cycle 0 -> meip_out high from cycle 2; CSRRW to 344 leaves mip unchanged.
- Write B80=32'h1, B00=32'hFFFF_FFFF, idle one cycle -> B00 reads 0, B80 reads 2. A write to C01 raises illegal_csr_out=1.
- VECTORED_EN: mtvec=32'h201, interrupt code 7 -> trap_address_out=32'h21C; exception -> 32'h200.

Source files
------------

// File: rtl/msrv32_csr_pkg.sv
// Shared definitions for the msrv32 machine-mode CSR unit: addresses, op encodings,
// status/interrupt bit positions, cause codes and the read-modify-write helper.
package msrv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPM3     = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHPM3H    = 12'hB83;
  localparam logic [11:0] CSR_TIME      = 12'hC01;
  localparam logic [11:0] CSR_TIMEH     = 12'hC81;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIX_MSI      = 3;
  localparam int MIX_MTI      = 7;
  localparam int MIX_MEI      = 11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_INT       = 4'd3;
  localparam logic [3:0] CAUSE_M_TMR_INT      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_INT      = 4'd11;

  function automatic logic [31:0] csr_rmw(input logic [1:0] op, input logic [31:0] old,
                                          input logic [31:0] src);
    case (op)
      CSR_OP_RW: return src;
      CSR_OP_RS: return old | src;
      CSR_OP_RC: return old & ~src;
      default:   return old;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_csr_counter.sv
// Wrapping event counter with independent 32-bit low/high half writes; a write
// in a cycle replaces that half and swallows the increment of that cycle.
module msrv32_csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]      ext;

  // Work in a 64-bit frame so widths from 32 to 64 share one code path.
  always_comb begin
    ext = 64'(cnt_q);
    if (wr_lo) ext[31:0]  = wdata;
    if (wr_hi) ext[63:32] = wdata;
    if (!wr_lo && !wr_hi && inc) ext = ext + 64'd1;
    cnt_d = ext[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/msrv32_csr_unit_param.sv
// Machine-mode CSR file for msrv32 with RMW ops, trap stacking, IRQ synchronisers
// and counters. Optional vectored mtvec mode via `MSRV32_CSR_VECTORED_EN.
module msrv32_csr_unit_param
  import msrv32_csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CNT_WIDTH   = 64,
  parameter int          NUM_HPM     = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  input  logic               wr_en_in,
  input  logic [11:0]        csr_addr_in,
  input  logic [2:0]         csr_op_in,
  input  logic [4:0]         csr_uimm_in,
  input  logic [XLEN-1:0]    csr_data_in,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [XLEN-1:0]    iadder_in,
  input  logic               i_or_e_in,
  input  logic [3:0]         cause_in,
  input  logic               set_cause_in,
  input  logic               set_epc_in,
  input  logic               mie_clear_in,
  input  logic               mie_set_in,
  input  logic               instret_inc_in,
  input  logic               ms_riscv32_mp_eirq_in,
  input  logic               ms_riscv32_mp_tirq_in,
  input  logic               ms_riscv32_mp_sirq_in,
  input  logic [63:0]        ms_riscv32_mp_rc_in,
  input  logic [NUM_HPM-1:0] hpm_event_in,
  output logic [XLEN-1:0]    csr_data_out,
  output logic               illegal_csr_out,
  output logic               mie_out,
  output logic               meie_out,
  output logic               mtie_out,
  output logic               msie_out,
  output logic               meip_out,
  output logic               mtip_out,
  output logic               msip_out,
  output logic [XLEN-1:0]    trap_address_out,
  output logic [XLEN-1:0]    epc_out
);

`ifdef MSRV32_CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic clk, rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  logic [1:0]  op;
  logic [31:0] src, old, wdata;
  logic        op_act, wr_intent, csr_impl, illegal, do_wr;

  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_en_q, mie_en_d;          // {MEIE, MTIE, MSIE}
  logic [2:0]  irq_s1_q, irq_s2_q;          // {e, t, s}
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mtval_q, mtval_d;
  logic        mcause_int_q, mcause_int_d;
  logic [3:0]  mcause_code_q, mcause_code_d;

  logic [CNT_WIDTH-1:0]              mcycle_val, minstret_val;
  logic [NUM_HPM-1:0][CNT_WIDTH-1:0] hpm_val;
  logic [63:0]                       mcycle_x, minstret_x;
  logic [NUM_HPM-1:0][63:0]          hpm_x;

  assign op        = csr_op_in[1:0];
  assign src       = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;
  assign op_act    = (op != CSR_OP_NONE);
  assign wr_intent = (op == CSR_OP_RW) || (src != 32'b0);

  assign mcycle_x   = 64'(mcycle_val);
  assign minstret_x = 64'(minstret_val);

  // Old-value read mux; unimplemented addresses read zero.
  always_comb begin
    csr_impl = 1'b1;
    old      = 32'b0;
    case (csr_addr_in)
      CSR_MSTATUS:   old = {19'b0, 2'b11, 3'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      CSR_MIE:       old = {20'b0, mie_en_q[2], 3'b0, mie_en_q[1], 3'b0, mie_en_q[0], 3'b0};
      CSR_MIP:       old = {20'b0, irq_s2_q[2], 3'b0, irq_s2_q[1], 3'b0, irq_s2_q[0], 3'b0};
      CSR_MTVEC:     old = mtvec_q;
      CSR_MSCRATCH:  old = mscratch_q;
      CSR_MEPC:      old = mepc_q;
      CSR_MCAUSE:    old = {mcause_int_q, 27'b0, mcause_code_q};
      CSR_MTVAL:     old = mtval_q;
      CSR_MCYCLE:    old = mcycle_x[31:0];
      CSR_MCYCLEH:   old = mcycle_x[63:32];
      CSR_MINSTRET:  old = minstret_x[31:0];
      CSR_MINSTRETH: old = minstret_x[63:32];
      CSR_TIME:      old = ms_riscv32_mp_rc_in[31:0];
      CSR_TIMEH:     old = ms_riscv32_mp_rc_in[63:32];
      default:       csr_impl = 1'b0;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (csr_addr_in == CSR_MHPM3 + 12'(i)) begin
        csr_impl = 1'b1;
        old      = hpm_x[i][31:0];
      end
      if (csr_addr_in == CSR_MHPM3H + 12'(i)) begin
        csr_impl = 1'b1;
        old      = hpm_x[i][63:32];
      end
    end
  end

  assign illegal = op_act && (!csr_impl || ((csr_addr_in[11:10] == 2'b11) && wr_intent));
  assign do_wr   = wr_en_in && op_act && wr_intent && !illegal;
  assign wdata   = csr_rmw(op, old, src);

  // Trap entry / mret take precedence over a CSR write in the same cycle.
  always_comb begin
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_en_d      = mie_en_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_int_d  = mcause_int_q;
    mcause_code_d = mcause_code_q;
    mtval_d       = mtval_q;

    if (mie_clear_in) begin
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mie_set_in) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (do_wr && csr_addr_in == CSR_MSTATUS) begin
      mst_mie_d  = wdata[MSTATUS_MIE];
      mst_mpie_d = wdata[MSTATUS_MPIE];
    end

    if (do_wr && csr_addr_in == CSR_MIE)
      mie_en_d = {wdata[MIX_MEI], wdata[MIX_MTI], wdata[MIX_MSI]};
    if (do_wr && csr_addr_in == CSR_MTVEC)    mtvec_d    = wdata & MTVEC_MASK;
    if (do_wr && csr_addr_in == CSR_MSCRATCH) mscratch_d = wdata;

    if (set_epc_in)                           mepc_d = pc_in & ~32'h3;
    else if (do_wr && csr_addr_in == CSR_MEPC) mepc_d = wdata & ~32'h3;

    if (set_cause_in) begin
      mcause_int_d  = i_or_e_in;
      mcause_code_d = cause_in;
      mtval_d       = i_or_e_in ? 32'b0 : iadder_in;
    end else begin
      if (do_wr && csr_addr_in == CSR_MCAUSE) begin
        mcause_int_d  = wdata[31];
        mcause_code_d = wdata[3:0];
      end
      if (do_wr && csr_addr_in == CSR_MTVAL) mtval_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_en_q      <= 3'b0;
      irq_s1_q      <= 3'b0;
      irq_s2_q      <= 3'b0;
      mtvec_q       <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q    <= 32'b0;
      mepc_q        <= 32'b0;
      mcause_int_q  <= 1'b0;
      mcause_code_q <= 4'b0;
      mtval_q       <= 32'b0;
    end else begin
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_en_q      <= mie_en_d;
      irq_s1_q      <= {ms_riscv32_mp_eirq_in, ms_riscv32_mp_tirq_in, ms_riscv32_mp_sirq_in};
      irq_s2_q      <= irq_s1_q;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_int_q  <= mcause_int_d;
      mcause_code_q <= mcause_code_d;
      mtval_q       <= mtval_d;
    end
  end

  msrv32_csr_counter #(.WIDTH(CNT_WIDTH)) u_mcycle (
    .clk(clk), .rst(rst), .inc(1'b1),
    .wr_lo(do_wr && csr_addr_in == CSR_MCYCLE),
    .wr_hi(do_wr && csr_addr_in == CSR_MCYCLEH),
    .wdata(wdata), .value(mcycle_val)
  );

  msrv32_csr_counter #(.WIDTH(CNT_WIDTH)) u_minstret (
    .clk(clk), .rst(rst), .inc(instret_inc_in),
    .wr_lo(do_wr && csr_addr_in == CSR_MINSTRET),
    .wr_hi(do_wr && csr_addr_in == CSR_MINSTRETH),
    .wdata(wdata), .value(minstret_val)
  );

  for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
    msrv32_csr_counter #(.WIDTH(CNT_WIDTH)) u_hpm (
      .clk(clk), .rst(rst), .inc(hpm_event_in[g]),
      .wr_lo(do_wr && csr_addr_in == CSR_MHPM3 + 12'(g)),
      .wr_hi(do_wr && csr_addr_in == CSR_MHPM3H + 12'(g)),
      .wdata(wdata), .value(hpm_val[g])
    );
    assign hpm_x[g] = 64'(hpm_val[g]);
  end

  always_comb begin
    trap_address_out = {mtvec_q[31:2], 2'b00};
`ifdef MSRV32_CSR_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && mcause_int_q)
      trap_address_out = {mtvec_q[31:2], 2'b00} + {26'b0, mcause_code_q, 2'b00};
`endif
  end

  assign csr_data_out    = old;
  assign illegal_csr_out = illegal;
  assign mie_out         = mst_mie_q;
  assign meie_out        = mie_en_q[2];
  assign mtie_out        = mie_en_q[1];
  assign msie_out        = mie_en_q[0];
  assign meip_out        = irq_s2_q[2];
  assign mtip_out        = irq_s2_q[1];
  assign msip_out        = irq_s2_q[0];
  assign epc_out         = mepc_q;

endmodule

// File: tb/tb_msrv32_csr_unit_param.sv
// Directed-vector bench for msrv32_csr_unit_param; honours MSRV32_CSR_VECTORED_EN.
module tb_msrv32_csr_unit_param;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_en, i_or_e, set_cause, set_epc, mie_clr, mie_set, instret;
  logic        eirq, tirq, sirq;
  logic [11:0] addr;
  logic [2:0]  op;
  logic [4:0]  uimm;
  logic [31:0] data, pc, iadder;
  logic [3:0]  cause;
  logic [63:0] rc;
  logic [1:0]  hpm_ev;
  logic [31:0] dout, trap, epc, v;
  logic        illegal, mie_o, meie, mtie, msie, meip, mtip, msip;

  int total = 0, bad = 0;

  msrv32_csr_unit_param #(.XLEN(32), .CNT_WIDTH(64), .NUM_HPM(2), .MTVEC_RESET(32'h100)) dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .wr_en_in(wr_en), .csr_addr_in(addr), .csr_op_in(op), .csr_uimm_in(uimm),
    .csr_data_in(data), .pc_in(pc), .iadder_in(iadder), .i_or_e_in(i_or_e),
    .cause_in(cause), .set_cause_in(set_cause), .set_epc_in(set_epc),
    .mie_clear_in(mie_clr), .mie_set_in(mie_set), .instret_inc_in(instret),
    .ms_riscv32_mp_eirq_in(eirq), .ms_riscv32_mp_tirq_in(tirq), .ms_riscv32_mp_sirq_in(sirq),
    .ms_riscv32_mp_rc_in(rc), .hpm_event_in(hpm_ev),
    .csr_data_out(dout), .illegal_csr_out(illegal),
    .mie_out(mie_o), .meie_out(meie), .mtie_out(mtie), .msie_out(msie),
    .meip_out(meip), .mtip_out(mtip), .msip_out(msip),
    .trap_address_out(trap), .epc_out(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Side-effect-free read: CSRRS with a zero register source.
  task automatic rd(input logic [11:0] a, output logic [31:0] val);
    wr_en = 1'b1; op = 3'b010; addr = a; data = 32'b0;
    #1;
    val = dout;
    wr_en = 1'b0; op = 3'b000;
  endtask

  task automatic wr(input logic [2:0] o, input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; op = o; addr = a; data = d; uimm = d[4:0];
    step();
    wr_en = 1'b0; op = 3'b000;
  endtask

  initial begin
    wr_en = 0; addr = 0; op = 0; uimm = 0; data = 0; pc = 0; iadder = 0;
    i_or_e = 0; cause = 0; set_cause = 0; set_epc = 0; mie_clr = 0; mie_set = 0;
    instret = 0; eirq = 0; tirq = 0; sirq = 0; rc = 0; hpm_ev = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // reset state
    chk("rst_trap", trap, 32'h100);
    chk("rst_epc", epc, 32'h0);
    chk("rst_flags", {25'b0, mie_o, meie, mtie, msie, meip, mtip, msip}, 32'h0);
    rd(12'h300, v); chk("rst_mstatus", v, 32'h1800);
    rd(12'h305, v); chk("rst_mtvec", v, 32'h100);
    rd(12'h341, v); chk("rst_mepc", v, 32'h0);

    // read returns pre-write value
    wr_en = 1; op = 3'b001; addr = 12'h340; data = 32'h1234_5678;
    #1 chk("rw_old", dout, 32'h0);
    step(); wr_en = 0; op = 0;
    rd(12'h340, v); chk("mscratch", v, 32'h1234_5678);

    // mie masking, RC with zero source
    wr(3'b010, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, v); chk("mie_rs", v, 32'h888);
    chk("mie_outs", {29'b0, meie, mtie, msie}, 32'h7);
    wr_en = 1; op = 3'b011; addr = 12'h304; data = 32'h0;
    #1 chk("rc0_illegal", {31'b0, illegal}, 32'h0);
    step(); wr_en = 0; op = 0;
    rd(12'h304, v); chk("mie_rc0", v, 32'h888);
    wr(3'b011, 12'h304, 32'h8);
    rd(12'h304, v); chk("mie_rc", v, 32'h880);

    // trap entry (with a racing mstatus write) then mret
    wr(3'b110, 12'h300, 32'h8);
    rd(12'h300, v); chk("mstatus_set", v, 32'h1808);
    pc = 32'h40; i_or_e = 0; cause = 4'd2; iadder = 32'hDEAD;
    set_epc = 1; set_cause = 1; mie_clr = 1;
    wr(3'b001, 12'h300, 32'h8);
    set_epc = 0; set_cause = 0; mie_clr = 0;
    chk("trap_epc", epc, 32'h40);
    rd(12'h342, v); chk("trap_mcause", v, 32'h2);
    rd(12'h343, v); chk("trap_mtval", v, 32'hDEAD);
    rd(12'h300, v); chk("trap_mstatus", v, 32'h1880);
    chk("trap_mie_out", {31'b0, mie_o}, 32'h0);
    mie_set = 1; step(); mie_set = 0;
    rd(12'h300, v); chk("mret_mstatus", v, 32'h1888);
    chk("mret_mie_out", {31'b0, mie_o}, 32'h1);

    // mepc: trap beats write, low bits forced 0
    pc = 32'h104; set_epc = 1;
    wr(3'b001, 12'h341, 32'h55);
    set_epc = 0;
    chk("epc_prio", epc, 32'h104);
    wr(3'b001, 12'h341, 32'h57);
    rd(12'h341, v); chk("mepc_align", v, 32'h54);

    // IRQ synchroniser latency
    eirq = 1;
    #1 chk("meip_c0", {31'b0, meip}, 32'h0);
    step(); chk("meip_c1", {31'b0, meip}, 32'h0);
    step(); chk("meip_c2", {31'b0, meip}, 32'h1);
    wr(3'b001, 12'h344, 32'h0);
    rd(12'h344, v); chk("mip_ro", v, 32'h800);
    eirq = 0;

    // mcycle half writes and carry
    wr(3'b001, 12'hB80, 32'h1);
    wr(3'b001, 12'hB00, 32'hFFFF_FFFF);
    step();
    rd(12'hB00, v); chk("mcycle_lo", v, 32'h0);
    rd(12'hB80, v); chk("mcycle_hi", v, 32'h2);

    // minstret, write suppresses increment
    instret = 1; repeat (3) step(); instret = 0;
    rd(12'hB02, v); chk("minstret", v, 32'h3);
    rd(12'hB82, v); chk("minstreth", v, 32'h0);
    instret = 1; wr(3'b001, 12'hB02, 32'h5); instret = 0;
    rd(12'hB02, v); chk("minstret_wr", v, 32'h5);

    // hpm counters
    hpm_ev = 2'b10; step(); step(); hpm_ev = 2'b00;
    rd(12'hB04, v); chk("hpm4", v, 32'h2);
    rd(12'hB03, v); chk("hpm3", v, 32'h0);

    // time view, illegal accesses
    rc = 64'h1234_5678_9ABC_DEF0;
    rd(12'hC01, v); chk("time_lo", v, 32'h9ABC_DEF0);
    rd(12'hC81, v); chk("time_hi", v, 32'h1234_5678);
    wr_en = 1; op = 3'b001; addr = 12'hC01; data = 32'h5;
    #1 chk("time_wr_ill", {31'b0, illegal}, 32'h1);
    step(); wr_en = 0; op = 0;
    wr_en = 1; op = 3'b010; addr = 12'h7C0; data = 32'h0;
    #1 chk("unimpl_ill", {31'b0, illegal}, 32'h1);
    chk("unimpl_rd", dout, 32'h0);
    wr_en = 0; op = 0;

    // mtvec mode / trap address
    wr(3'b001, 12'h305, 32'h201);
    rd(12'h305, v);
`ifdef MSRV32_CSR_VECTORED_EN
    chk("mtvec_rd", v, 32'h201);
`else
    chk("mtvec_rd", v, 32'h200);
`endif
    i_or_e = 1; cause = 4'd7; set_cause = 1; step(); set_cause = 0;
`ifdef MSRV32_CSR_VECTORED_EN
    chk("trap_vec_int", trap, 32'h21C);
`else
    chk("trap_vec_int", trap, 32'h200);
`endif
    rd(12'h342, v); chk("mcause_int", v, 32'h8000_0007);
    rd(12'h343, v); chk("mtval_int", v, 32'h0);
    i_or_e = 0; cause = 4'd2; iadder = 32'h77; set_cause = 1; step(); set_cause = 0;
    chk("trap_vec_exc", trap, 32'h200);
    rd(12'h343, v); chk("mtval_exc", v, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
